// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus of the serial subtractor
interface serial_subtractor_if #(parameter int N = 11);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;
  modport master (output start, a, b, bin, input diff, bout, ovf, busy, done);
  modport slave  (input start, a, b, bin, output diff, bout, ovf, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one full-subtractor bit per clock, LSB first
module serial_subtractor #(
  parameter int N = 11
) (
  input logic             clk,
  input logic             rst_n,
  serial_subtractor_if.slave io
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, RUN} state_t;
  state_t       state, state_nx;
  logic [N-1:0] a_sh, b_sh, res, res_nx, diff_q;
  logic [CW-1:0] cnt;
  logic         brw, a_msb, b_msb, bout_q, ovf_q, done_q;
  logic         x, y, d, nb, last;
  // full-subtractor cell, completion detect and next-state logic
  always_comb begin
    x        = a_sh[0];
    y        = b_sh[0];
    d        = x ^ y ^ brw;
    nb       = (~x & y) | (~(x ^ y) & brw);
    res_nx   = {d, res[N-1:1]};
    last     = (state == RUN) && (cnt == CW'(N - 1));
    state_nx = (state == IDLE) ? (io.start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // operand shift registers, borrow flop, bit counter and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (state == IDLE && io.start) begin
        a_sh  <= io.a;
        b_sh  <= io.b;
        brw   <= io.bin;
        cnt   <= '0;
        res   <= '0;
        a_msb <= io.a[N-1];
        b_msb <= io.b[N-1];
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        brw  <= nb;
        cnt  <= cnt + 1'b1;
        res  <= res_nx;
      end
      if (last) begin
        diff_q <= res_nx;
        bout_q <= nb;
        ovf_q  <= (a_msb != b_msb) && (res_nx[N-1] != a_msb);
      end
    end
  end
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf  = ovf_q;
  assign io.done = done_q;
  assign io.busy = (state == RUN);
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b - bin, processing one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the combinational n_bit_adder datapath.
- It trades area for latency and is used where a subtract result may take N+1 cycles.
- Control uses a start/busy/done handshake.

Parameters:
N, 11, operand and result width in bits (legal range N >= 2)

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  request pulse; accepted only when busy=0
a  input  N  minuend, sampled on the accepted-start edge
b  input  N  subtrahend, sampled on the accepted-start edge
bin  input  1  borrow-in, sampled on the accepted-start edge
diff  output  N  result a - b - bin modulo 2^N
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)
ovf  output  1  two's-complement signed overflow of the subtraction
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse marking a valid result

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - diff=0, bout=0, ovf=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- Reset takes effect immediately and abandons any operation in flight; no done pulse follows.
- States are IDLE and RUN.
- IDLE:
  - busy=0.
  - On a rising edge with start=1, load a, b and bin into internal registers, clear the counter, and go to RUN (busy=1 from that edge).
  - start=0 keeps the state in IDLE, and diff/bout/ovf hold their last values.
- RUN, each rising edge:
  - Take bit x = a_sh[0], y = b_sh[0], c = borrow.
  - Compute d = x ^ y ^ c and nb = (~x & y) | (~(x ^ y) & c).
  - Shift d into the MSB of the result register (right shift).
  - Shift a_sh and b_sh right; borrow <= nb; counter++.
- On the edge that processes bit N-1:
  - diff <= completed result and bout <= nb.
  - ovf <= (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the latched operand MSBs.
  - done <= 1 for exactly one cycle, busy <= 0, state -> IDLE.
- Latency: an accepted start at edge T0 produces done high in cycle T0+N (N bit edges after the load edge). busy is high for exactly N cycles.
- diff, bout and ovf update only at completion; they are stable from done until the next completion.
- start while busy=1 is ignored; operands are not resampled and the running operation is unaffected.
- start=1 in the done cycle (busy=0) is accepted: back-to-back operations with no idle gap.
- Counter width is $clog2(N); wrap is impossible because the state exits at count N-1.
- All arithmetic is modulo 2^N; no saturation.

Test Plan:
- N=11, a=5, b=3, bin=0, one-cycle start -> busy high 11 cycles, done pulse 11 cycles after the load edge; diff=11'h002, bout=0, ovf=0.
- a=3, b=5, bin=0 -> diff=11'h7FE, bout=1, ovf=0. Then a=0, b=0, bin=1 -> diff=11'h7FF, bout=1, ovf=0.
- a=11'h400 (-1024), b=1, bin=0 -> diff=11'h3FF, bout=0, ovf=1. Then a=11'h3FF, b=11'h7FF (-1) -> diff=11'h400, bout=1, ovf=1.
- Start a=9, b=4; pulse start again at cycle 3 with a=100, b=1 -> second start ignored; single done with diff=5. Assert start in the done cycle with a=7, b=7 -> next done 11 cycles later with diff=0, bout=0.
- Start a=20, b=6; drop rst_n at cycle 5 -> busy, done, diff, bout and ovf go to 0 immediately; no done after release. A fresh start with a=20, b=6 -> diff=14.
- Randomised 1000 operations, including bin=1, checked against the reference model {bout,diff} = a - b - bin in N+1 bits, and ovf against the signed-overflow formula.
